// File: rtl/banked_memory_pkg.sv
// Shared byte-lane definitions and helpers for the banked memory (banked_memory_bank, banked_memory).
package banked_memory_pkg;

  localparam int BYTE_BITS = 8;

  typedef logic [BYTE_BITS-1:0] byte_t;

  // Even parity: the stored bit makes the total count of ones in byte + bit even.
  function automatic logic even_parity(byte_t value);
    return ^value;
  endfunction

endpackage

// File: rtl/banked_memory_bank.sv
// One single-ported bank: row array with byte-masked write and registered read.
// Parity storage per byte is built only when BANKED_MEMORY_PARITY_EN is defined.
module banked_memory_bank
  import banked_memory_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ROW_BITS = 8
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ROW_BITS-1:0]   row,
  input  logic [WIDTH/8-1:0]    mask,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rerr
);

  localparam int ROWS = 2 ** ROW_BITS;
  localparam int NB   = WIDTH / 8;

  logic [WIDTH-1:0] mem [ROWS];

  // NOTE: neither the array nor the read register is reset; contents are undefined
  // after power-up and a reset would stop the array mapping onto an SRAM macro.
  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (mask[i]) mem[row][i*BYTE_BITS +: BYTE_BITS] <= wdata[i*BYTE_BITS +: BYTE_BITS];
      end
    end
    if (en && !we) rdata <= mem[row];
  end

`ifdef BANKED_MEMORY_PARITY_EN
  logic [NB-1:0] par [ROWS];
  logic [NB-1:0] rpar;

  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (mask[i]) par[row][i] <= even_parity(wdata[i*BYTE_BITS +: BYTE_BITS]);
      end
    end
    if (en && !we) rpar <= par[row];
  end

  always_comb begin
    rerr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (even_parity(rdata[i*BYTE_BITS +: BYTE_BITS]) != rpar[i]) rerr = 1'b1;
    end
  end
`else
  assign rerr = 1'b0;
`endif

endmodule

// File: rtl/banked_memory.sv
// Multi-port, multi-bank SRAM with per-bank round-robin arbitration and a per-port read return pipe.
// Optional feature macro: BANKED_MEMORY_PARITY_EN (per-byte even parity, reported on parityError).
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 32,
  parameter int NUM_PORTS    = 2,
  parameter int NUM_BANKS    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_PORTS-1:0]                      reqValid,
  output logic [NUM_PORTS-1:0]                      reqReady,
  input  logic [NUM_PORTS-1:0]                      reqWrite,
  input  logic [NUM_PORTS-1:0][$clog2(DEPTH)-1:0]   reqAddress,
  input  logic [NUM_PORTS-1:0][WIDTH/8-1:0]         reqByteMask,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0]           reqData,
  output logic [NUM_PORTS-1:0]                      readValid,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]           readData,
  output logic [NUM_PORTS-1:0]                      parityError
);

  localparam int AW        = $clog2(DEPTH);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int RW        = (AW - BANK_BITS > 0) ? AW - BANK_BITS : 1;
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NB        = WIDTH / 8;

  function automatic logic [PW-1:0] rr_index(logic [PW-1:0] base, int k);
    return PW'((int'(base) + k) % NUM_PORTS);
  endfunction

  logic [NUM_PORTS-1:0][BW-1:0]    bank_of;
  logic [NUM_PORTS-1:0][RW-1:0]    row_of;
  logic [NUM_BANKS-1:0][PW-1:0]    rr_ptr;
  logic [NUM_BANKS-1:0][PW-1:0]    grant_port;
  logic [NUM_BANKS-1:0]            grant_any;
  logic [NUM_BANKS-1:0]            bank_en;
  logic [NUM_BANKS-1:0]            bank_we;
  logic [NUM_BANKS-1:0][RW-1:0]    bank_row;
  logic [NUM_BANKS-1:0][NB-1:0]    bank_mask;
  logic [NUM_BANKS-1:0][WIDTH-1:0] bank_wdata;
  logic [NUM_BANKS-1:0][WIDTH-1:0] bank_rdata;
  logic [NUM_BANKS-1:0]            bank_rerr;

  // Low address bits interleave consecutive words across banks.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_of[p] = BW'(reqAddress[p]) & BW'(NUM_BANKS - 1);
      row_of[p]  = RW'(reqAddress[p] >> BANK_BITS);
    end
  end

  // NOTE: every always_comb output gets a default before any conditional update so no latch is inferred.
  always_comb begin
    grant_any  = '0;
    grant_port = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!grant_any[b] && reqValid[rr_index(rr_ptr[b], k)] &&
            bank_of[rr_index(rr_ptr[b], k)] == BW'(b)) begin
          grant_any[b]  = 1'b1;
          grant_port[b] = rr_index(rr_ptr[b], k);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      reqReady[p] = !reset && reqValid[p] && grant_any[bank_of[p]] &&
                    grant_port[bank_of[p]] == PW'(p);
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b]    = grant_any[b] && !reset;
      bank_we[b]    = reqWrite[grant_port[b]];
      bank_row[b]   = row_of[grant_port[b]];
      bank_mask[b]  = reqByteMask[grant_port[b]];
      bank_wdata[b] = reqData[grant_port[b]];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (grant_any[b]) rr_ptr[b] <= rr_index(grant_port[b], 1);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    banked_memory_bank #(.WIDTH(WIDTH), .ROW_BITS(RW)) u_bank (
      .clock (clock),
      .en    (bank_en[b]),
      .we    (bank_we[b]),
      .row   (bank_row[b]),
      .mask  (bank_mask[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b]),
      .rerr  (bank_rerr[b])
    );
  end

  // Return pipe: remember which bank serves each port's read; the bank data is ready one cycle later.
  logic [NUM_PORTS-1:0]            valid1;
  logic [NUM_PORTS-1:0][BW-1:0]    bank1;
  logic [NUM_PORTS-1:0]            ret_now;
  logic [NUM_PORTS-1:0][WIDTH-1:0] ret_data;
  logic [NUM_PORTS-1:0]            ret_err;
  logic [NUM_PORTS-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clock) begin
    if (reset) valid1 <= '0;
    else       valid1 <= reqReady & ~reqWrite;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reqReady[p]) bank1[p] <= bank_of[p];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ret_now[p]  = valid1[p] && !reset;
      ret_data[p] = bank_rdata[bank1[p]];
      ret_err[p]  = bank_rerr[bank1[p]];
    end
  end

  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (ret_now[p]) data_q[p] <= ret_data[p];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [NUM_PORTS-1:0] valid2;
    logic [NUM_PORTS-1:0] err_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        valid2 <= '0;
        err_q  <= '0;
      end else begin
        valid2 <= valid1;
        err_q  <= ret_err & ret_now;
      end
    end

    assign readValid   = valid2 & ~{NUM_PORTS{reset}};
    assign readData    = data_q;
    assign parityError = valid2 & err_q & ~{NUM_PORTS{reset}};
  end else begin : g_lat1
    assign readValid   = ret_now;
    assign parityError = ret_now & ret_err;
    always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        readData[p] = ret_now[p] ? ret_data[p] : data_q[p];
      end
    end
  end

endmodule

// File: tb/tb_banked_memory.sv
// Randomized bench for banked_memory: READ_LATENCY 1 and 2 instances share stimulus and a reference model.
module tb_banked_memory;

  localparam int DEPTH = 1024;
  localparam int NP    = 2;
  localparam int NBK   = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                   reset;
  logic [NP-1:0]          reqValid, reqWrite;
  logic [NP-1:0][9:0]     reqAddress;
  logic [NP-1:0][3:0]     reqByteMask;
  logic [NP-1:0][31:0]    reqData;
  logic [NP-1:0]          ready1, ready2, rv1, rv2, pe1, pe2;
  logic [NP-1:0][31:0]    rd1, rd2;

  banked_memory #(.DEPTH(DEPTH), .WIDTH(32), .NUM_PORTS(NP), .NUM_BANKS(NBK), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(ready1), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqByteMask(reqByteMask), .reqData(reqData),
    .readValid(rv1), .readData(rd1), .parityError(pe1));

  banked_memory #(.DEPTH(DEPTH), .WIDTH(32), .NUM_PORTS(NP), .NUM_BANKS(NBK), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(ready2), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqByteMask(reqByteMask), .reqData(reqData),
    .readValid(rv2), .readData(rd2), .parityError(pe2));

  typedef struct {
    bit          valid;
    bit          write;
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } item_t;

  typedef struct {
    logic [31:0] data;
    bit          perr;
    int          due;
  } resp_t;

  item_t       sq [NP][$];
  resp_t       rq [2][NP][$];
  logic [31:0] mem [DEPTH];
  logic [3:0]  corrupt [DEPTH];
  int          ptr [NBK];
  logic [31:0] last [2][NP];
  bit          have_last [2][NP];
  int          cyc, n_total, n_bad;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(int p, bit write, int addr, logic [3:0] mask, logic [31:0] data);
    item_t it;
    it.valid = 1'b1;
    it.write = write;
    it.addr  = 10'(addr);
    it.mask  = mask;
    it.data  = data;
    sq[p].push_back(it);
  endtask

  // One clock cycle: drive queue heads, predict grants and returns, compare, then advance the model.
  task automatic step();
    item_t       cur [NP];
    bit          exp_rdy [NP];
    int          winner [NBK];
    bit          got_v, got_pe, exp_v;
    logic [31:0] got_d;
    resp_t       r;
    int          p;
    for (int i = 0; i < NP; i++) begin
      if (sq[i].size() > 0) cur[i] = sq[i][0];
      else cur[i] = '{valid: 1'b0, write: 1'b0, addr: '0, mask: '0, data: '0};
      reqValid[i]    = cur[i].valid;
      reqWrite[i]    = cur[i].write;
      reqAddress[i]  = cur[i].addr;
      reqByteMask[i] = cur[i].mask;
      reqData[i]     = cur[i].data;
      exp_rdy[i]     = 1'b0;
    end
    #3;
    for (int b = 0; b < NBK; b++) begin
      winner[b] = -1;
      if (!reset) begin
        for (int k = 0; k < NP; k++) begin
          p = (ptr[b] + k) % NP;
          if (winner[b] < 0 && cur[p].valid && int'(cur[p].addr) % NBK == b) begin
            winner[b]  = p;
            exp_rdy[p] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      check($sformatf("ready_lat1_p%0d", i), 32'(ready1[i]), 32'(exp_rdy[i]));
      check($sformatf("ready_lat2_p%0d", i), 32'(ready2[i]), 32'(exp_rdy[i]));
    end
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < NP; i++) begin
        got_v  = (l == 0) ? rv1[i] : rv2[i];
        got_pe = (l == 0) ? pe1[i] : pe2[i];
        got_d  = (l == 0) ? rd1[i] : rd2[i];
        exp_v  = !reset && rq[l][i].size() > 0 && rq[l][i][0].due == cyc;
        check($sformatf("rvalid_lat%0d_p%0d", l + 1, i), 32'(got_v), 32'(exp_v));
        if (exp_v) begin
          r = rq[l][i].pop_front();
          check($sformatf("rdata_lat%0d_p%0d", l + 1, i), got_d, r.data);
          check($sformatf("perr_lat%0d_p%0d", l + 1, i), 32'(got_pe), 32'(r.perr));
          last[l][i]      = r.data;
          have_last[l][i] = 1'b1;
        end else begin
          check($sformatf("perr_idle_lat%0d_p%0d", l + 1, i), 32'(got_pe), 32'd0);
          if (have_last[l][i]) check($sformatf("rdata_hold_lat%0d_p%0d", l + 1, i), got_d, last[l][i]);
        end
      end
    end
    if (reset) begin
      for (int l = 0; l < 2; l++) for (int i = 0; i < NP; i++) rq[l][i].delete();
      for (int b = 0; b < NBK; b++) ptr[b] = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (exp_rdy[i] && !cur[i].write) begin
          r.data = mem[cur[i].addr];
          r.perr = |corrupt[cur[i].addr];
          r.due  = cyc + 1;
          rq[0][i].push_back(r);
          r.due  = cyc + 2;
          rq[1][i].push_back(r);
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (exp_rdy[i] && cur[i].write) begin
          for (int j = 0; j < 4; j++) begin
            if (cur[i].mask[j]) mem[cur[i].addr][j*8 +: 8] = cur[i].data[j*8 +: 8];
          end
          corrupt[cur[i].addr] = corrupt[cur[i].addr] & ~cur[i].mask;
        end
        if (sq[i].size() > 0 && (exp_rdy[i] || !cur[i].valid)) void'(sq[i].pop_front());
      end
      for (int b = 0; b < NBK; b++) if (winner[b] >= 0) ptr[b] = (winner[b] + 1) % NP;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(int max_cycles);
    int n;
    n = 0;
    while ((sq[0].size() > 0 || sq[1].size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", 32'(sq[0].size() + sq[1].size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    item_t idle;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    idle    = '{valid: 1'b0, write: 1'b0, addr: '0, mask: '0, data: '0};
    for (int a = 0; a < DEPTH; a++) corrupt[a] = 4'h0;
    for (int b = 0; b < NBK; b++) ptr[b] = 0;
    reset = 1'b1;
    reqValid = '0; reqWrite = '0; reqAddress = '0; reqByteMask = '0; reqData = '0;
    @(posedge clock);
    #1;

    // Requests presented during reset must not be accepted.
    push(0, 1'b1, 5, 4'hF, 32'hDEADBEEF);
    push(1, 1'b1, 6, 4'hF, 32'h0BADF00D);
    step();
    step();
    reset = 1'b0;

    // Preload every word so the model knows all contents.
    for (int a = 0; a < DEPTH; a += 2) begin
      push(0, 1'b1, a, 4'hF, $urandom);
      push(1, 1'b1, a + 1, 4'hF, $urandom);
    end
    run(2000);

    push(0, 1'b1, 5, 4'hF, 32'hDEADBEEF);
    push(0, 1'b0, 5, 4'h0, 32'h0);
    run(50);

    push(0, 1'b1, 8, 4'hF, 32'h11223344);
    push(0, 1'b1, 8, 4'h2, 32'h0000AA00);
    push(0, 1'b1, 8, 4'h0, 32'hFFFFFFFF);
    push(0, 1'b0, 8, 4'h0, 32'h0);
    run(50);

    // Same-bank conflict, twice, to exercise pointer rotation.
    repeat (2) begin
      push(0, 1'b0, 0, 4'h0, 32'h0);
      push(1, 1'b0, 4, 4'h0, 32'h0);
      run(50);
    end

    // Distinct banks, then sustained back-to-back streams.
    push(0, 1'b0, 1, 4'h0, 32'h0);
    push(1, 1'b0, 2, 4'h0, 32'h0);
    run(50);
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 1 + 4 * i, 4'h0, 32'h0);
      push(1, 1'b0, 2 + 4 * i, 4'h0, 32'h0);
    end
    run(50);

    // Read accepted, reset asserted the following cycle: the read must vanish.
    push(0, 1'b0, 5, 4'h0, 32'h0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    push(0, 1'b0, 5, 4'h0, 32'h0);
    push(1, 1'b0, 8, 4'h0, 32'h0);
    run(50);

`ifdef BANKED_MEMORY_PARITY_EN
    dut.g_bank[1].u_bank.mem[0][0]  = ~dut.g_bank[1].u_bank.mem[0][0];
    dut2.g_bank[1].u_bank.mem[0][0] = ~dut2.g_bank[1].u_bank.mem[0][0];
    mem[1][0]     = ~mem[1][0];
    corrupt[1][0] = 1'b1;
    push(0, 1'b0, 1, 4'h0, 32'h0);
    push(1, 1'b0, 2, 4'h0, 32'h0);
    run(50);
    push(0, 1'b1, 1, 4'h1, 32'h000000A5);
    push(0, 1'b0, 1, 4'h0, 32'h0);
    run(50);
`endif

    // Randomized traffic with a bias toward a few addresses to force bank conflicts.
    for (int i = 0; i < 1200; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          sq[p].push_back(idle);
        end else begin
          push(p, $urandom_range(0, 9) < 4,
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
               4'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    run(20000);

    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("resp_left_lat%0d_p%0d", l + 1, p), 32'(rq[l][p].size()), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
